stepper_phase_driver: RTL and testbench

- Downstream stage of the strobe-counting motor controller: consumes its `mover` enable level and drives the four stepper coil outputs INA, INA2, INB, INB2.
- Generates the step rate with a prescaler and sequences the coil phase table in either direction.
- Holds the last phase energised for a programmable time after `mover` drops, then de-energises the coils.
- Keeps a wrapping step count for debug.

---
 rtl/stepper_phase_driver.sv | 157 +++++++++++++++
 tb/tb_stepper_phase_driver.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/stepper_phase_driver.sv
// Stepper coil phase sequencer: prescaled step rate, bidirectional phase table,
// post-run hold and wrapping step count. Define STEPPER_HALF_STEP_EN for 8-phase half-stepping.
module stepper_phase_driver #(
  parameter int unsigned CLK_DIV     = 50000,
  parameter int unsigned HOLD_CYCLES = 25000,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             mover,
  input  logic             dir,
  output logic             INA,
  output logic             INA2,
  output logic             INB,
  output logic             INB2,
  output logic             busy,
  output logic             step_pulse,
  output logic [CNT_W-1:0] step_count
);

  // state | meaning
  // IDLE  | coils off, waiting for mover
  // RUN   | coils energised, stepping every CLK_DIV cycles
  // HOLD  | coils hold last phase for HOLD_CYCLES after mover drops
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [PW-1:0] PRE_LAST  = PW'(CLK_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
  localparam bit HOLD_EN = (HOLD_CYCLES > 0);

`ifdef STEPPER_HALF_STEP_EN
  localparam int unsigned IW = 3;
`else
  localparam int unsigned IW = 2;
`endif

  // coil pattern in {INA,INA2,INB,INB2} order
  function automatic logic [3:0] phase_coils(input logic [IW-1:0] idx);
    logic [3:0] c;
    c = 4'b0000;
`ifdef STEPPER_HALF_STEP_EN
    case (idx)
      3'd0: c = 4'b1000;
      3'd1: c = 4'b1010;
      3'd2: c = 4'b0010;
      3'd3: c = 4'b0110;
      3'd4: c = 4'b0100;
      3'd5: c = 4'b0101;
      3'd6: c = 4'b0001;
      3'd7: c = 4'b1001;
    endcase
`else
    case (idx)
      2'd0: c = 4'b1010;
      2'd1: c = 4'b0110;
      2'd2: c = 4'b0101;
      2'd3: c = 4'b1001;
    endcase
`endif
    return c;
  endfunction

  logic [1:0]       state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d, idx_step;
  logic [PW-1:0]    pre_q, pre_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [3:0]       coil_q, coil_d;
  logic             pulse_q, pulse_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign idx_step = dir ? (idx_q + IW'(1)) : (idx_q - IW'(1));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pre_d   = pre_q;
    hold_d  = hold_q;
    coil_d  = coil_q;
    pulse_d = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        coil_d = 4'b0000;
        if (mover) begin
          state_d = ST_RUN;
          coil_d  = phase_coils(idx_q);
          pre_d   = '0;
        end
      end
      ST_RUN: begin
        // a falling mover beats a coincident step
        if (!mover) begin
          if (HOLD_EN) begin
            state_d = ST_HOLD;
            hold_d  = '0;
          end else begin
            state_d = ST_IDLE;
            coil_d  = 4'b0000;
          end
        end else if (pre_q == PRE_LAST) begin
          pre_d   = '0;
          idx_d   = idx_step;
          coil_d  = phase_coils(idx_step);
          pulse_d = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
        end else begin
          pre_d = pre_q + PW'(1);
        end
      end
      ST_HOLD: begin
        if (mover) begin
          state_d = ST_RUN;
          pre_d   = '0;
        end else if (hold_q == HOLD_LAST) begin
          state_d = ST_IDLE;
          coil_d  = 4'b0000;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        coil_d  = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      pre_q   <= '0;
      hold_q  <= '0;
      coil_q  <= 4'b0000;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pre_q   <= pre_d;
      hold_q  <= hold_d;
      coil_q  <= coil_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
    end
  end

  assign {INA, INA2, INB, INB2} = coil_q;
  assign busy       = (state_q != ST_IDLE);
  assign step_pulse = pulse_q;
  assign step_count = cnt_q;

endmodule

// File: tb/tb_stepper_phase_driver.sv
// Scoreboard bench: a behavioural model queues the expected outputs of every cycle,
// a monitor pops and compares them; a second small instance covers CLK_DIV=1 and count wrap.
module tb_stepper_phase_driver;

  localparam int unsigned DIV  = 4;
  localparam int unsigned HOLD = 3;

`ifdef STEPPER_HALF_STEP_EN
  localparam int NPH = 8;
  localparam logic [3:0] FWD5 = 4'b0101;
  localparam logic [3:0] REV2 = 4'b0110;
`else
  localparam int NPH = 4;
  localparam logic [3:0] FWD5 = 4'b0110;
  localparam logic [3:0] REV2 = 4'b1001;
`endif

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic mover = 1'b0, dir = 1'b1, mover2 = 1'b0;
  logic ina, ina2, inb, inb2, busy, pulse;
  logic [15:0] cnt;
  logic jna, jna2, jnb, jnb2, busy2, pulse2;
  logic [3:0] cnt2;

  always #5 CLK = ~CLK;

  stepper_phase_driver #(.CLK_DIV(DIV), .HOLD_CYCLES(HOLD), .CNT_W(16)) dut (
    .CLK(CLK), .RST(RST), .mover(mover), .dir(dir),
    .INA(ina), .INA2(ina2), .INB(inb), .INB2(inb2),
    .busy(busy), .step_pulse(pulse), .step_count(cnt));

  stepper_phase_driver #(.CLK_DIV(1), .HOLD_CYCLES(0), .CNT_W(4)) dut2 (
    .CLK(CLK), .RST(RST), .mover(mover2), .dir(1'b1),
    .INA(jna), .INA2(jna2), .INB(jnb), .INB2(jnb2),
    .busy(busy2), .step_pulse(pulse2), .step_count(cnt2));

  wire [3:0] coils  = {ina, ina2, inb, inb2};
  wire [3:0] coils2 = {jna, jna2, jnb, jnb2};

  typedef struct packed {
    logic [3:0]  coils;
    logic        busy;
    logic        pulse;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference model: position on the phase circle, cycles left until the next step,
  // cycles of hold remaining.
  logic [3:0] tbl [NPH];
  int         m_mode;   // 0 off, 1 running, 2 holding
  int         m_pos, m_wait, m_left;
  logic [3:0] m_coils;
  logic       m_pulse;
  logic [15:0] m_cnt;

  initial begin
`ifdef STEPPER_HALF_STEP_EN
    tbl = '{4'b1000, 4'b1010, 4'b0010, 4'b0110, 4'b0100, 4'b0101, 4'b0001, 4'b1001};
`else
    tbl = '{4'b1010, 4'b0110, 4'b0101, 4'b1001};
`endif
  end

  task automatic model_edge();
    m_pulse = 1'b0;
    if (RST) begin
      m_mode = 0; m_pos = 0; m_coils = 4'b0000; m_cnt = 16'd0;
    end else if (m_mode == 0) begin
      if (mover) begin
        m_mode = 1; m_coils = tbl[m_pos]; m_wait = DIV;
      end
    end else if (m_mode == 1) begin
      if (!mover) begin
        m_mode = 2; m_left = HOLD;
      end else begin
        m_wait = m_wait - 1;
        if (m_wait == 0) begin
          m_pos   = (m_pos + (dir ? 1 : NPH - 1)) % NPH;
          m_coils = tbl[m_pos];
          m_pulse = 1'b1;
          m_cnt   = m_cnt + 16'd1;
          m_wait  = DIV;
        end
      end
    end else begin
      if (mover) begin
        m_mode = 1; m_wait = DIV;
      end else begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_mode = 0; m_coils = 4'b0000;
        end
      end
    end
    exp_q.push_back('{coils: m_coils, busy: (m_mode != 0), pulse: m_pulse, cnt: m_cnt});
  endtask

  task automatic drive(input logic r, input logic m, input logic d, input logic m2);
    @(negedge CLK);
    RST = r; mover = m; dir = d; mover2 = m2;
    @(posedge CLK);
    model_edge();
  endtask

  task automatic drive_n(input int n, input logic m, input logic d);
    for (int i = 0; i < n; i++) drive(1'b0, m, d, 1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("coils", {28'd0, coils}, {28'd0, e.coils});
        chk("busy", {31'd0, busy}, {31'd0, e.busy});
        chk("step_pulse", {31'd0, pulse}, {31'd0, e.pulse});
        chk("step_count", {16'd0, cnt}, {16'd0, e.cnt});
      end
    end
  end

  initial begin : stim
    logic rr, mm, dd;
    // reset with mover high, then one idle cycle after release
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    chk("post_reset_coils", {28'd0, coils}, 32'd0);
    chk("post_reset_busy", {31'd0, busy}, 32'd0);
    chk("post_reset_cnt", {16'd0, cnt}, 32'd0);

    // forward run: entry edge plus steps at edges 4..20
    drive_n(21, 1'b1, 1'b1);
    #1;
    chk("fwd_cnt", {16'd0, cnt}, 32'd5);
    chk("fwd_coils", {28'd0, coils}, {28'd0, FWD5});
    chk("fwd_last_pulse", {31'd0, pulse}, 32'd1);

    // hold for 3 cycles, then de-energise
    drive_n(3, 1'b0, 1'b1);
    #1;
    chk("hold_coils", {28'd0, coils}, {28'd0, FWD5});
    chk("hold_busy", {31'd0, busy}, 32'd1);
    drive_n(1, 1'b0, 1'b1);
    #1;
    chk("idle_coils", {28'd0, coils}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // re-enter, drop into hold, resume in reverse from hold
    drive_n(1, 1'b1, 1'b0);
    drive_n(1, 1'b0, 1'b0);
    drive_n(1, 1'b1, 1'b0);
    #1;
    chk("resume_coils", {28'd0, coils}, {28'd0, FWD5});
    drive_n(8, 1'b1, 1'b0);
    #1;
    chk("rev_coils", {28'd0, coils}, {28'd0, REV2});
    chk("rev_cnt", {16'd0, cnt}, 32'd7);

    // mover drops exactly on the terminal prescaler cycle
    drive_n(3, 1'b1, 1'b0);
    drive_n(1, 1'b0, 1'b0);
    #1;
    chk("prio_pulse", {31'd0, pulse}, 32'd0);
    chk("prio_cnt", {16'd0, cnt}, 32'd7);
    chk("prio_busy", {31'd0, busy}, 32'd1);
    chk("prio_coils", {28'd0, coils}, {28'd0, REV2});
    drive_n(4, 1'b0, 1'b0);

    // second instance: one step per clock, 4-bit count wrap, no hold
    for (int i = 0; i < 16; i++) drive(1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    chk("div1_cnt15", {28'd0, cnt2}, 32'd15);
    chk("div1_pulse", {31'd0, pulse2}, 32'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    chk("wrap_cnt", {28'd0, cnt2}, 32'd0);
    chk("wrap_pulse", {31'd0, pulse2}, 32'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("nohold_coils", {28'd0, coils2}, 32'd0);
    chk("nohold_busy", {31'd0, busy2}, 32'd0);
    chk("nohold_pulse", {31'd0, pulse2}, 32'd0);

    // randomized traffic against the model
    mm = 1'b0;
    for (int i = 0; i < 600; i++) begin
      rr = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 7) == 0) mm = ~mm;
      dd = ($urandom_range(0, 5) == 0) ? ~dir : dir;
      drive(rr, mm, dd, 1'b0);
    end
    drive_n(6, 1'b0, 1'b1);

    @(negedge CLK);
    #5;
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
